// File: rtl/reg_file_wb_ctrl.sv
// Writeback controller for the register file: merges ALU and buffered load results into one
// registered write per cycle and tracks registers with outstanding results in busy_vec.
module reg_file_wb_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LQ_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       rf_wr_en,
  output logic [ADDR_W-1:0]          rf_wr_addr,
  output logic [DATA_W-1:0]          rf_wr_data,
  output logic [2**ADDR_W-1:0]       busy_vec,
  output logic [$clog2(LQ_DEPTH):0]  lq_count
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);

  logic [ADDR_W-1:0] lq_addr [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic                 lq_full;
  logic                 alu_fire;
  logic                 push;
  logic                 pop;
  logic [2**ADDR_W-1:0] busy_next;

  always_comb begin
    lq_full   = (lq_count == FULL_CNT);
    alu_ready = !rst && !lq_full;
    ld_ready  = !rst && !lq_full;
    alu_fire  = alu_valid && alu_ready;
    push      = ld_valid && ld_ready;
    // The FIFO only gets the write port when no ALU result is accepted this cycle.
    pop       = !rst && !alu_fire && (lq_count != '0);
  end

  // Clear from the write currently on the RF port, then set from issue so a same-address set wins.
  always_comb begin
    busy_next = busy_vec;
    if (rf_wr_en) busy_next[rf_wr_addr] = 1'b0;
    if (issue_valid) busy_next[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_addr[wr_ptr] <= ld_addr;
      lq_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lq_count   <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      busy_vec   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   lq_count <= lq_count + CNT_W'(1);
        2'b01:   lq_count <= lq_count - CNT_W'(1);
        default: lq_count <= lq_count;
      endcase

      rf_wr_en <= alu_fire || pop;
      if (alu_fire) begin
        rf_wr_addr <= alu_addr;
        rf_wr_data <= alu_data;
      end else if (pop) begin
        rf_wr_addr <= lq_addr[rd_ptr];
        rf_wr_data <= lq_data[rd_ptr];
      end

      busy_vec <= busy_next;
    end
  end

endmodule

// File: tb/tb_reg_file_wb_ctrl.sv
// Self-checking bench for reg_file_wb_ctrl: a behavioural model predicts each RF write into a
// scoreboard queue, which is drained and compared as writes appear on rf_wr_*.
module tb_reg_file_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        issue_valid;
  logic [2:0]  issue_addr;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [7:0]  busy_vec;
  logic [1:0]  lq_count;

  reg_file_wb_ctrl #(.DATA_W(16), .ADDR_W(3), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy_vec(busy_vec), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         m_lq[$];
  logic [7:0]  m_busy = '0;
  logic        m_wr_en = 1'b0;
  logic [2:0]  m_wr_addr = '0;
  int unsigned cycle = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // One clock: drive inputs, predict, clock, then compare outputs 1 time unit after the edge.
  task automatic step(input logic r,
                      input logic a_v, input logic [2:0] a_a, input logic [15:0] a_d,
                      input logic l_v, input logic [2:0] l_a, input logic [15:0] l_d,
                      input logic i_v, input logic [2:0] i_a);
    logic       m_ready;
    logic       fire;
    logic       push;
    logic       pop;
    logic       exp_en;
    wr_t        e;
    wr_t        head;
    logic [7:0] nb;
    rst = r;
    alu_valid = a_v; alu_addr = a_a; alu_data = a_d;
    ld_valid = l_v;  ld_addr = l_a;  ld_data = l_d;
    issue_valid = i_v; issue_addr = i_a;
    #1;
    m_ready = !r && (m_lq.size() != 2);
    check_eq("alu_ready", alu_ready, m_ready);
    check_eq("ld_ready", ld_ready, m_ready);

    fire = a_v && m_ready;
    push = l_v && m_ready;
    pop  = !r && !fire && (m_lq.size() != 0);
    if (r) begin
      m_lq.delete();
      m_busy = '0;
      m_wr_en = 1'b0;
    end else begin
      nb = m_busy;
      if (m_wr_en) nb[m_wr_addr] = 1'b0;
      if (i_v) nb[i_a] = 1'b1;
      m_busy = nb;
      m_wr_en = fire || pop;
      if (fire) begin
        e.cyc = cycle + 1; e.addr = a_a; e.data = a_d;
        exp_q.push_back(e);
        m_wr_addr = a_a;
      end else if (pop) begin
        e = m_lq.pop_front();
        e.cyc = cycle + 1;
        exp_q.push_back(e);
        m_wr_addr = e.addr;
      end
      if (push) begin
        e.cyc = 0; e.addr = l_a; e.data = l_d;
        m_lq.push_back(e);
      end
    end

    @(posedge clk);
    cycle++;
    #1;
    exp_en = (exp_q.size() != 0) && (exp_q[0].cyc == cycle);
    check_eq("rf_wr_en", rf_wr_en, exp_en);
    if (rf_wr_en && exp_q.size() != 0) begin
      head = exp_q.pop_front();
      check_eq("rf_wr_addr", rf_wr_addr, head.addr);
      check_eq("rf_wr_data", rf_wr_data, head.data);
    end
    check_eq("lq_count", lq_count, m_lq.size());
    check_eq("busy_vec", busy_vec, m_busy);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    issue_valid = 0; issue_addr = 0;
    @(negedge clk);

    // Reset held two cycles, then release.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_wr_addr", rf_wr_addr, 3'd0);
    check_eq("rst_wr_data", rf_wr_data, 16'h0000);
    idle(1);

    // Single ALU write, visible for exactly one cycle.
    step(0, 1, 3'd3, 16'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // ALU and load in the same cycle: ALU first, load next.
    step(0, 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 0);
    idle(3);

    // Fill the FIFO while the ALU keeps the port, then let it drain.
    step(0, 1, 3'd0, 16'h0100, 1, 3'd4, 16'h0004, 0, 0);
    step(0, 1, 3'd7, 16'h0700, 1, 3'd6, 16'h0006, 0, 0);
    step(0, 1, 3'd0, 16'h0200, 1, 3'd5, 16'h0055, 0, 0);
    idle(2);
    step(0, 1, 3'd7, 16'h0777, 0, 0, 0, 0, 0);
    idle(2);

    // Scoreboard: set by issue, cleared by the commit, and set-wins on the commit edge.
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
    step(0, 0, 0, 0, 1, 3'd5, 16'h5A5A, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
    step(0, 0, 0, 0, 1, 3'd5, 16'hA5A5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
    idle(2);

    // Reset with two queued loads drops them.
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd2);
    step(0, 1, 3'd1, 16'h1111, 1, 3'd3, 16'h3333, 0, 0);
    step(0, 1, 3'd1, 16'h2222, 1, 3'd4, 16'h4444, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic against the model.
    for (int unsigned k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom),
           ($urandom_range(0, 1) == 0), 3'($urandom), 16'($urandom),
           ($urandom_range(0, 2) == 0), 3'($urandom));
    end
    idle(4);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
